// File: rtl/mux_src_sequencer.sv
// mux_src_sequencer
//   Operand/select source for a WIDTH-bit 2:1 mux. Two operand registers are
//   loaded through a valid/ready handshake while idle. After a start, sel
//   alternates through run_len phases of DWELL cycles each. Then done pulses
//   for one cycle.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   load_valid/ready    operand load handshake (ready only while idle)
//   load_a, load_b      operand values captured on an accepted load
//   start, run_len      begin a run of run_len phases (ignored if run_len==0)
//   abort               end a run at once, with no done pulse
//   a, b, sel           to the mux a/b/sel inputs
//   busy, done          run in progress / one-cycle completion pulse
//   phase_cnt           phases completed in the current or last run
module mux_src_sequencer #(
  parameter int WIDTH = 4,
  parameter int DWELL = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  input  logic             start,
  input  logic [CNT_W-1:0] run_len,
  input  logic             abort,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] phase_cnt
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [DW_W-1:0]  dwell, dwell_nxt;
  logic [CNT_W-1:0] len, len_nxt;
  logic [CNT_W-1:0] phase_cnt_nxt;
  logic [WIDTH-1:0] a_nxt, b_nxt;
  logic             sel_nxt;
  logic [CNT_W:0]   phase_inc;
  logic             more_phases;

  // One extra bit so phase_cnt+1 cannot wrap before the compare.
  assign phase_inc   = {1'b0, phase_cnt} + (CNT_W+1)'(1);
  assign more_phases = phase_inc < {1'b0, len};

  // These decode the state register only, so they stay free of input paths.
  assign load_ready = (state == IDLE);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dwell     <= '0;
      len       <= '0;
      phase_cnt <= '0;
      a         <= '0;
      b         <= '0;
      sel       <= 1'b0;
    end else begin
      state     <= state_nxt;
      dwell     <= dwell_nxt;
      len       <= len_nxt;
      phase_cnt <= phase_cnt_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      sel       <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    dwell_nxt     = dwell;
    len_nxt       = len;
    phase_cnt_nxt = phase_cnt;
    a_nxt         = a;
    b_nxt         = b;
    sel_nxt       = sel;
    case (state)
      IDLE: begin
        if (load_valid) begin
          a_nxt = load_a;
          b_nxt = load_b;
        end
        if (start && (run_len != '0)) begin
          len_nxt       = run_len;
          phase_cnt_nxt = '0;
          dwell_nxt     = '0;
          sel_nxt       = 1'b0;
          state_nxt     = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          // Abort wins over a coinciding phase end, so phase_cnt holds.
          sel_nxt   = 1'b0;
          state_nxt = IDLE;
        end else if (dwell == DW_LAST) begin
          dwell_nxt     = '0;
          phase_cnt_nxt = phase_inc[CNT_W-1:0];
          if (more_phases) begin
            sel_nxt = ~sel;
          end else begin
            sel_nxt   = 1'b0;
            state_nxt = DONE;
          end
        end else begin
          dwell_nxt = dwell + DW_W'(1);
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
